// File: rtl/bus_arb_if.sv
// Bundle of the three master request ports, the shared slave-side bus and the halt outputs.
// The arbiter connects through the master modport; the surrounding environment uses the slave modport.
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

interface bus_arb_if;

  logic                        i_jtag_req;
  logic                        i_jtag_we;
  logic [`RV32_DATA_WIDTH-1:0] i_jtag_addr;
  logic [`RV32_DATA_WIDTH-1:0] i_jtag_wdata;
  logic [3:0]                  i_jtag_be;
  logic                        o_jtag_ack;

  logic                        i_mem_req;
  logic                        i_mem_we;
  logic [`RV32_DATA_WIDTH-1:0] i_mem_addr;
  logic [`RV32_DATA_WIDTH-1:0] i_mem_wdata;
  logic [3:0]                  i_mem_be;
  logic                        o_mem_ack;

  logic                        i_if_req;
  logic                        i_if_we;
  logic [`RV32_DATA_WIDTH-1:0] i_if_addr;
  logic [`RV32_DATA_WIDTH-1:0] i_if_wdata;
  logic [3:0]                  i_if_be;
  logic                        o_if_ack;

  logic [`RV32_DATA_WIDTH-1:0] o_rdata;
  logic                        o_err;

  logic                        o_bus_req;
  logic                        o_bus_we;
  logic [31:0]                 o_bus_addr;
  logic [31:0]                 o_bus_wdata;
  logic [3:0]                  o_bus_be;
  logic                        i_bus_ack;
  logic [`RV32_DATA_WIDTH-1:0] i_bus_rdata;

  logic                        o_bus_mem_halt;
  logic                        o_bus_if_halt;

  modport master (
    input  i_jtag_req, i_jtag_we, i_jtag_addr, i_jtag_wdata, i_jtag_be,
    input  i_mem_req,  i_mem_we,  i_mem_addr,  i_mem_wdata,  i_mem_be,
    input  i_if_req,   i_if_we,   i_if_addr,   i_if_wdata,   i_if_be,
    input  i_bus_ack,  i_bus_rdata,
    output o_jtag_ack, o_mem_ack, o_if_ack,
    output o_rdata, o_err,
    output o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    output o_bus_mem_halt, o_bus_if_halt
  );

  modport slave (
    output i_jtag_req, i_jtag_we, i_jtag_addr, i_jtag_wdata, i_jtag_be,
    output i_mem_req,  i_mem_we,  i_mem_addr,  i_mem_wdata,  i_mem_be,
    output i_if_req,   i_if_we,   i_if_addr,   i_if_wdata,   i_if_be,
    output i_bus_ack,  i_bus_rdata,
    input  o_jtag_ack, o_mem_ack, o_if_ack,
    input  o_rdata, o_err,
    input  o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be,
    input  o_bus_mem_halt, o_bus_if_halt
  );

endinterface

// File: rtl/bus_arb.sv
// Three-master single-slave bus arbiter: jtag has absolute priority, mem and if alternate,
// and a granted transaction is aborted with an error pulse if the slave never acknowledges.
module bus_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  bus_arb_if.master bus
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  typedef enum logic [1:0] {
    G_NONE,
    G_JTAG,
    G_MEM,
    G_IF
  } grant_t;

  localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  grant_t      r_grant;
  grant_t      w_grant_nxt;
  logic        r_ptr_mem;
  logic        w_ptr_mem_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        w_timeout;
  logic        w_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_grant   <= G_NONE;
      r_ptr_mem <= 1'b1;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_ptr_mem <= w_ptr_mem_nxt;
      r_cnt     <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_grant_nxt     = r_grant;
    w_ptr_mem_nxt   = r_ptr_mem;
    w_cnt_nxt       = r_cnt;
    w_timeout       = 1'b0;
    w_done          = 1'b0;
    bus.o_bus_req   = 1'b0;
    bus.o_bus_we    = 1'b0;
    bus.o_bus_addr  = '0;
    bus.o_bus_wdata = '0;
    bus.o_bus_be    = '0;
    bus.o_jtag_ack  = 1'b0;
    bus.o_mem_ack   = 1'b0;
    bus.o_if_ack    = 1'b0;
    bus.o_err       = 1'b0;
    bus.o_rdata     = '0;

    case (r_state)
      S_IDLE: begin
        // The pointer flips only when mem or if is served, so jtag traffic leaves the alternation intact.
        if (bus.i_jtag_req) begin
          w_grant_nxt = G_JTAG;
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = '0;
        end else if (bus.i_mem_req && (!bus.i_if_req || r_ptr_mem)) begin
          w_grant_nxt   = G_MEM;
          w_ptr_mem_nxt = 1'b0;
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = '0;
        end else if (bus.i_if_req) begin
          w_grant_nxt   = G_IF;
          w_ptr_mem_nxt = 1'b1;
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = '0;
        end
      end

      S_BUSY: begin
        w_timeout     = !bus.i_bus_ack && (r_cnt == LP_CNT_LAST);
        w_done        = bus.i_bus_ack || w_timeout;
        bus.o_bus_req = !w_timeout;

        case (r_grant)
          G_JTAG: begin
            bus.o_bus_we    = bus.i_jtag_we;
            bus.o_bus_addr  = bus.i_jtag_addr;
            bus.o_bus_wdata = bus.i_jtag_wdata;
            bus.o_bus_be    = bus.i_jtag_be;
            bus.o_jtag_ack  = w_done;
          end
          G_MEM: begin
            bus.o_bus_we    = bus.i_mem_we;
            bus.o_bus_addr  = bus.i_mem_addr;
            bus.o_bus_wdata = bus.i_mem_wdata;
            bus.o_bus_be    = bus.i_mem_be;
            bus.o_mem_ack   = w_done;
          end
          G_IF: begin
            bus.o_bus_we    = bus.i_if_we;
            bus.o_bus_addr  = bus.i_if_addr;
            bus.o_bus_wdata = bus.i_if_wdata;
            bus.o_bus_be    = bus.i_if_be;
            bus.o_if_ack    = w_done;
          end
          default: begin
          end
        endcase

        bus.o_err   = w_timeout;
        bus.o_rdata = bus.i_bus_ack ? bus.i_bus_rdata : '0;
        w_cnt_nxt   = r_cnt + 16'd1;

        if (w_done) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = G_NONE;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = G_NONE;
      end
    endcase
  end

  assign bus.o_bus_mem_halt = bus.i_mem_req & ~bus.o_mem_ack;
  assign bus.o_bus_if_halt  = bus.i_if_req  & ~bus.o_if_ack;

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb with TIMEOUT_CYCLES=4: inputs change on the falling edge,
// outputs are checked 1 time unit later, and every expected value is hand-derived.
module tb_bus_arb;

  localparam logic [31:0] JTAG_ADDR  = 32'h1000_0004;
  localparam logic [31:0] JTAG_WDATA = 32'h1111_2222;
  localparam logic [31:0] MEM_ADDR   = 32'h2000_0040;
  localparam logic [31:0] MEM_WDATA  = 32'hCAFE_F00D;
  localparam logic [31:0] IF_ADDR    = 32'h0000_0100;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bus_arb_if bif();

  bus_arb #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic jreq, input logic mreq, input logic ireq,
                               input logic ack, input logic [31:0] rdata);
    @(negedge clk);
    bif.i_jtag_req  = jreq;
    bif.i_mem_req   = mreq;
    bif.i_if_req    = ireq;
    bif.i_bus_ack   = ack;
    bif.i_bus_rdata = rdata;
    #1;
  endtask

  initial begin
    rst_n            = 1'b0;
    bif.i_jtag_req   = 1'b0;
    bif.i_jtag_we    = 1'b1;
    bif.i_jtag_addr  = JTAG_ADDR;
    bif.i_jtag_wdata = JTAG_WDATA;
    bif.i_jtag_be    = 4'h1;
    bif.i_mem_req    = 1'b0;
    bif.i_mem_we     = 1'b1;
    bif.i_mem_addr   = MEM_ADDR;
    bif.i_mem_wdata  = MEM_WDATA;
    bif.i_mem_be     = 4'hC;
    bif.i_if_req     = 1'b0;
    bif.i_if_we      = 1'b0;
    bif.i_if_addr    = IF_ADDR;
    bif.i_if_wdata   = 32'h0;
    bif.i_if_be      = 4'hF;
    bif.i_bus_ack    = 1'b0;
    bif.i_bus_rdata  = 32'h0;

    // Reset state: everything quiet, halts still follow the requests
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h1234_5678);
    checkOutput("rstBusReq", bif.o_bus_req, 32'd0);
    checkOutput("rstAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'd0);
    checkOutput("rstRdata", bif.o_rdata, 32'd0);
    checkOutput("rstErr", bif.o_err, 32'd0);
    checkOutput("rstBusAddr", bif.o_bus_addr, 32'd0);
    checkOutput("rstHalts", {bif.o_bus_mem_halt, bif.o_bus_if_halt}, 32'b01);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // mem and if both requesting, slave acks at once: mem, if, mem, if
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("altIdleReq", bif.o_bus_req, 32'd0);
      checkOutput("altIdleAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'hA0 + 32'(k));
      checkOutput("altAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack},
                  (k % 2 == 0) ? 32'b010 : 32'b001);
      checkOutput("altAddr", bif.o_bus_addr, (k % 2 == 0) ? MEM_ADDR : IF_ADDR);
      checkOutput("altRdata", bif.o_rdata, 32'hA0 + 32'(k));
      checkOutput("altHalts", {bif.o_bus_mem_halt, bif.o_bus_if_halt},
                  (k % 2 == 0) ? 32'b01 : 32'b10);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("altEndReq", bif.o_bus_req, 32'd0);

    // Single if read, slave acks 3 cycles after o_bus_req rises
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("ifIdleReq", bif.o_bus_req, 32'd0);
    checkOutput("ifIdleHalt", bif.o_bus_if_halt, 32'd1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("ifWaitReq", bif.o_bus_req, 32'd1);
      checkOutput("ifWaitAddr", bif.o_bus_addr, IF_ADDR);
      checkOutput("ifWaitWe", bif.o_bus_we, 32'd0);
      checkOutput("ifWaitBe", bif.o_bus_be, 32'hF);
      checkOutput("ifWaitAck", bif.o_if_ack, 32'd0);
      checkOutput("ifWaitHalt", bif.o_bus_if_halt, 32'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    checkOutput("ifAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b001);
    checkOutput("ifRdata", bif.o_rdata, 32'hDEAD_BEEF);
    checkOutput("ifErr", bif.o_err, 32'd0);
    checkOutput("ifHalt", bif.o_bus_if_halt, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("ifAfterReq", bif.o_bus_req, 32'd0);
    checkOutput("ifAfterAck", bif.o_if_ack, 32'd0);

    // All three requesting: jtag, then mem, then if
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("prioIdleReq", bif.o_bus_req, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h1);
    checkOutput("prioJtagAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b100);
    checkOutput("prioJtagAddr", bif.o_bus_addr, JTAG_ADDR);
    checkOutput("prioJtagWdata", bif.o_bus_wdata, JTAG_WDATA);
    checkOutput("prioJtagBe", bif.o_bus_be, 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("prioGapReq", bif.o_bus_req, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h2);
    checkOutput("prioMemAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b010);
    checkOutput("prioMemWdata", bif.o_bus_wdata, MEM_WDATA);
    checkOutput("prioMemWe", bif.o_bus_we, 32'd1);
    checkOutput("prioMemBe", bif.o_bus_be, 32'hC);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h3);
    checkOutput("prioIfAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b001);
    checkOutput("prioIfRdata", bif.o_rdata, 32'h3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // mem write, slave silent: abort with error in the 4th busy cycle
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h55AA_55AA);
      checkOutput("toWaitReq", bif.o_bus_req, 32'd1);
      checkOutput("toWaitAck", bif.o_mem_ack, 32'd0);
      checkOutput("toWaitErr", bif.o_err, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h55AA_55AA);
    checkOutput("toAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b010);
    checkOutput("toErr", bif.o_err, 32'd1);
    checkOutput("toRdata", bif.o_rdata, 32'd0);
    checkOutput("toBusReq", bif.o_bus_req, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h77);
    checkOutput("idleAckIgnored", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'd0);
    checkOutput("idleAckRdata", bif.o_rdata, 32'd0);
    checkOutput("idleAckErr", bif.o_err, 32'd0);
    checkOutput("idleAckBusReq", bif.o_bus_req, 32'd0);

    // Reset during an if transaction, then regrant after release
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("rbBusyReq", bif.o_bus_req, 32'd1);
    checkOutput("rbBusyAddr", bif.o_bus_addr, IF_ADDR);
    rst_n = 1'b0;
    #1;
    checkOutput("rbRstReq", bif.o_bus_req, 32'd0);
    checkOutput("rbRstAddr", bif.o_bus_addr, 32'd0);
    checkOutput("rbRstHalt", bif.o_bus_if_halt, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0BAD);
    checkOutput("rbRstAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'd0);
    checkOutput("rbRstRdata", bif.o_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rbRelReq", bif.o_bus_req, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_600D);
    checkOutput("rbAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b001);
    checkOutput("rbRdata", bif.o_rdata, 32'h0000_600D);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // mem drops its request mid-transaction; the transfer still completes
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("dropIdleHalt", bif.o_bus_mem_halt, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("dropBusyReq", bif.o_bus_req, 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("dropHeldReq", bif.o_bus_req, 32'd1);
    checkOutput("dropHeldAddr", bif.o_bus_addr, MEM_ADDR);
    checkOutput("dropHeldHalt", bif.o_bus_mem_halt, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
    checkOutput("dropAcks", {bif.o_jtag_ack, bif.o_mem_ack, bif.o_if_ack}, 32'b010);
    checkOutput("dropRdata", bif.o_rdata, 32'h99);
    checkOutput("dropHalt", bif.o_bus_mem_halt, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("dropEndReq", bif.o_bus_req, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, meaning the maximum cycles a granted transaction waits for i_bus_ack before being aborted with an error (legal range 2..65535).
REQ-002 SHALL have i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have, for each master X in {jtag, mem, if}, i_X_req  input  1  request, held high until o_X_ack.
REQ-005 SHALL have, per master, i_X_we  input  1  write enable.
REQ-006 SHALL have, per master, i_X_addr  input  `RV32_DATA_WIDTH  byte address.
REQ-007 SHALL have, per master, i_X_wdata  input  `RV32_DATA_WIDTH  write data.
REQ-008 SHALL have, per master, i_X_be  input  4  byte enables.
REQ-009 SHALL have, per master, o_X_ack  output  1  one-cycle completion pulse.
REQ-010 SHALL have o_rdata  output  `RV32_DATA_WIDTH  read data, valid with any o_X_ack.
REQ-011 SHALL have o_err  output  1  one-cycle pulse, coincident with o_X_ack, flagging timeout.
REQ-012 SHALL have o_bus_req, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_be  output  1/1/32/32/4  slave-side transaction.
REQ-013 SHALL have i_bus_ack  input  1 and i_bus_rdata  input  `RV32_DATA_WIDTH  slave response.
REQ-014 SHALL have o_bus_mem_halt and o_bus_if_halt  output  1  pipeline halt requests to the stall/flush controller.

Function
REQ-015 SHALL implement FSM states IDLE and BUSY; IDLE->BUSY when any i_X_req is high; BUSY->IDLE on i_bus_ack or timeout.
REQ-016 SHALL, in IDLE, latch grant: jtag absolute priority; between mem and if, priority alternates, with the master not served last winning when both request.
REQ-017 SHALL reset the alternating pointer to favour mem.
REQ-018 SHALL, in BUSY, drive o_bus_req=1 and o_bus_we/addr/wdata/be combinationally from the granted master's inputs; in IDLE, all o_bus_* SHALL be 0.
REQ-019 SHALL, when i_bus_ack=1 in BUSY, pulse o_X_ack of the granted master in that same cycle, with o_rdata=i_bus_rdata.
REQ-020 SHALL give minimum latency of 2 cycles: req sampled at edge N enters BUSY, ack earliest in cycle N+1.
REQ-021 SHALL never issue a new grant in the cycle an ack occurs; the next arbitration is in the following IDLE cycle.
REQ-022 SHALL count cycles in BUSY with a counter cleared on entry; when it reaches TIMEOUT_CYCLES-1 without i_bus_ack, SHALL pulse o_X_ack and o_err, set o_rdata=0, drop o_bus_req and return to IDLE.
REQ-023 SHALL ignore i_bus_ack while in IDLE.
REQ-024 SHALL complete a BUSY transaction even if the granted master deasserts i_X_req mid-transaction; o_X_ack still pulses.
REQ-025 SHALL assert o_bus_X_halt (X in mem, if) = i_X_req AND NOT o_X_ack, combinationally.
REQ-026 SHALL hold o_X_ack, o_err, o_rdata at 0 in every cycle without completion.

Reset
REQ-027 SHALL, while i_rst_n=0, force IDLE, counter 0, grant none, pointer=mem, all outputs 0 (halts follow REQ-025 with o_X_ack=0).
REQ-028 SHALL abandon any in-flight transaction on reset assertion without emitting ack; after release, arbitration restarts from IDLE.

Verification
REQ-029 Single if read at 0x0000_0100, slave acks 3 cycles after o_bus_req with rdata 0xDEADBEEF -> o_if_ack one cycle, o_rdata=0xDEADBEEF, o_bus_if_halt high until that cycle.
REQ-030 mem and if request together continuously, slave acks immediately -> grants alternate mem, if, mem, if; each ack 2 cycles apart.
REQ-031 jtag, mem, if request together -> jtag served first regardless of pointer, then mem, then if.
REQ-032 TIMEOUT_CYCLES=4, mem write, slave never acks -> o_mem_ack and o_err pulse in 4th BUSY cycle, o_rdata=0, FSM back to IDLE.
REQ-033 Reset asserted during BUSY with if granted -> outputs 0 immediately, no ack; after release, if (still requesting) regranted, normal completion.
REQ-034 mem granted, i_mem_req dropped before ack -> o_bus_req stays high until i_bus_ack, o_mem_ack pulses, o_bus_mem_halt stays 0.
